// File: rtl/acc_core_pkg.sv
// acc_core_pkg
// Shared definitions for the accumulator core: opcode encodings, the
// instruction-cycle state enum and the instruction field geometry.
//
// The opcode always lives in the top OPC_W bits of the instruction word. The
// data address occupies the low ADDR_SIZE bits. The immediate occupies every
// bit below the opcode. Both widths depend on module parameters, so only the
// opcode width is fixed here.
package acc_core_pkg;

  // Instruction field geometry
  localparam int OPC_W = 4;  // opcode width, top of the instruction word

  // Instruction cycle states
  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEM    = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_LD   = 4'h0;
  localparam logic [OPC_W-1:0] OP_ST   = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'h3;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'h4;
  localparam logic [OPC_W-1:0] OP_JGE  = 4'h5;
  localparam logic [OPC_W-1:0] OP_JNZ  = 4'h6;
  localparam logic [OPC_W-1:0] OP_HALT = 4'h7;
  localparam logic [OPC_W-1:0] OP_AND  = 4'h8;
  localparam logic [OPC_W-1:0] OP_OR   = 4'h9;
  localparam logic [OPC_W-1:0] OP_XOR  = 4'hA;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'hB;
  localparam logic [OPC_W-1:0] OP_SHL  = 4'hC;
  localparam logic [OPC_W-1:0] OP_SHR  = 4'hD;
  localparam logic [OPC_W-1:0] OP_CALL = 4'hE;
  localparam logic [OPC_W-1:0] OP_RET  = 4'hF;

  // True for every opcode that needs a data-port access in the MEM state.
  function automatic logic op_uses_dmem(input logic [OPC_W-1:0] op);
    case (op)
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_uses_dmem = 1'b1;
      default:                                             op_uses_dmem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/acc_core_alu.sv
// acc_core_alu
// Purely combinational accumulator datapath. It produces the new accumulator
// value for one opcode from the current accumulator and an operand. The
// operand is the data-port read word for memory ops, or the zero-extended
// immediate for LDI.
//
// Ports:
//   op_i       in   OPC_W      opcode selecting the operation
//   acc_i      in   WORD_SIZE  current accumulator
//   operand_i  in   WORD_SIZE  memory word or extended immediate
//   result_o   out  WORD_SIZE  new accumulator value (acc_i if op has none)
module acc_core_alu
  import acc_core_pkg::*;
#(
  parameter int WORD_SIZE = 16
) (
  input  logic [OPC_W-1:0]     op_i,
  input  logic [WORD_SIZE-1:0] acc_i,
  input  logic [WORD_SIZE-1:0] operand_i,
  output logic [WORD_SIZE-1:0] result_o
);

  always_comb begin
    result_o = acc_i;
    case (op_i)
      OP_LD, OP_LDI: result_o = operand_i;
      // Add and subtract wrap modulo 2^WORD_SIZE; no flags are kept.
      OP_ADD:        result_o = acc_i + operand_i;
      OP_SUB:        result_o = acc_i - operand_i;
      OP_AND:        result_o = acc_i & operand_i;
      OP_OR:         result_o = acc_i | operand_i;
      OP_XOR:        result_o = acc_i ^ operand_i;
      OP_SHL:        result_o = {acc_i[WORD_SIZE-2:0], 1'b0};
      OP_SHR:        result_o = {1'b0, acc_i[WORD_SIZE-1:1]};
      default:       result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// acc_core
// Parametrised single-accumulator processor core. Instruction and data
// memories live outside the core. Each is reached through a request/ready
// handshake, and the memory may insert any number of wait states.
// Each instruction runs FETCH -> DECODE [-> MEM] and then returns to FETCH.
// HALT and unsupported opcodes park the core in HALT until reset.
//
// Build option: define ACC_CORE_CALL_EN to add a single link register and
// the CALL (E) / RET (F) opcodes. Without it those opcodes are illegal.
//
// Parameters:
//   WORD_SIZE     data/instruction width, must be >= ADDR_SIZE + 4
//   ADDR_SIZE     instruction and data address width
//   RESET_VECTOR  instruction pointer value after reset
//
// Ports:
//   sysclk      in   1          clock, all state on the rising edge
//   rst         in   1          synchronous active-high reset
//   imem_req    out  1          instruction fetch request (FETCH state)
//   imem_addr   out  ADDR_SIZE  fetch address, equals ip
//   imem_rdata  in   WORD_SIZE  instruction word, valid with imem_ready
//   imem_ready  in   1          fetch completes this cycle
//   dmem_req    out  1          data access request (MEM state)
//   dmem_we     out  1          write qualifier, only for ST
//   dmem_addr   out  ADDR_SIZE  address field of the current instruction
//   dmem_wdata  out  WORD_SIZE  accumulator
//   dmem_rdata  in   WORD_SIZE  read data, valid with dmem_ready
//   dmem_ready  in   1          data access completes this cycle
//   acc_out     out  WORD_SIZE  accumulator
//   ip_out      out  ADDR_SIZE  instruction pointer
//   halted      out  1          core stopped
//   illegal     out  1          core stopped on an unsupported opcode
module acc_core
  import acc_core_pkg::*;
#(
  parameter int                   WORD_SIZE    = 16,
  parameter int                   ADDR_SIZE    = 12,
  parameter logic [ADDR_SIZE-1:0] RESET_VECTOR = '0
) (
  input  logic                 sysclk,
  input  logic                 rst,
  output logic                 imem_req,
  output logic [ADDR_SIZE-1:0] imem_addr,
  input  logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [ADDR_SIZE-1:0] dmem_addr,
  output logic [WORD_SIZE-1:0] dmem_wdata,
  input  logic [WORD_SIZE-1:0] dmem_rdata,
  input  logic                 dmem_ready,
  output logic [WORD_SIZE-1:0] acc_out,
  output logic [ADDR_SIZE-1:0] ip_out,
  output logic                 halted,
  output logic                 illegal
);

  localparam int IMM_W = WORD_SIZE - OPC_W;

  // Architectural state
  state_e                 state_q,   state_d;
  logic [WORD_SIZE-1:0]   acc_q,     acc_d;
  logic [WORD_SIZE-1:0]   ir_q,      ir_d;
  logic [ADDR_SIZE-1:0]   ip_q,      ip_d;
  logic                   illegal_q, illegal_d;
`ifdef ACC_CORE_CALL_EN
  logic [ADDR_SIZE-1:0]   lr_q,      lr_d;
`endif

  // Instruction fields of the latched instruction
  logic [OPC_W-1:0]     opcode;
  logic [ADDR_SIZE-1:0] addr_s;
  logic [WORD_SIZE-1:0] imm_ext;
  logic [WORD_SIZE-1:0] alu_operand;
  logic [WORD_SIZE-1:0] alu_result;

  assign opcode  = ir_q[WORD_SIZE-1 -: OPC_W];
  assign addr_s  = ir_q[ADDR_SIZE-1:0];
  assign imm_ext = {{OPC_W{1'b0}}, ir_q[IMM_W-1:0]};

  // The single ALU serves both the MEM-state ops (operand from the data
  // port) and the DECODE-state ops (LDI immediate; shifts ignore it).
  assign alu_operand = (state_q == S_MEM) ? dmem_rdata : imm_ext;

  acc_core_alu #(
    .WORD_SIZE (WORD_SIZE)
  ) u_alu (
    .op_i      (opcode),
    .acc_i     (acc_q),
    .operand_i (alu_operand),
    .result_o  (alu_result)
  );

  // Next-state logic. The ready inputs only matter in the state that owns the
  // matching request. A ready seen in any other state is ignored.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ir_d      = ir_q;
    ip_d      = ip_q;
    illegal_d = illegal_q;
`ifdef ACC_CORE_CALL_EN
    lr_d      = lr_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          ip_d    = ip_q + ADDR_SIZE'(1);  // wraps at 2^ADDR_SIZE
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_FETCH;
        if (op_uses_dmem(opcode)) begin
          state_d = S_MEM;
        end else begin
          // ip_q already points past this instruction. A taken branch
          // simply overwrites it.
          case (opcode)
            OP_JMP:  ip_d = addr_s;
            OP_JGE:  if (!acc_q[WORD_SIZE-1]) ip_d = addr_s;
            OP_JNZ:  if (acc_q != '0) ip_d = addr_s;
            OP_HALT: state_d = S_HALT;
            OP_LDI, OP_SHL, OP_SHR: acc_d = alu_result;
`ifdef ACC_CORE_CALL_EN
            OP_CALL: begin
              lr_d = ip_q;  // return address is the incremented ip
              ip_d = addr_s;
            end
            OP_RET:  ip_d = lr_q;
`endif
            default: begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          endcase
        end
      end

      S_MEM: begin
        // Address and write data come straight from ir/acc. Both stay
        // frozen while waiting, so the request is stable until ready.
        if (dmem_ready) begin
          if (opcode != OP_ST) acc_d = alu_result;
          state_d = S_FETCH;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      acc_q     <= '0;
      ir_q      <= '0;
      ip_q      <= RESET_VECTOR;
      illegal_q <= 1'b0;
`ifdef ACC_CORE_CALL_EN
      lr_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ir_q      <= ir_d;
      ip_q      <= ip_d;
      illegal_q <= illegal_d;
`ifdef ACC_CORE_CALL_EN
      lr_q      <= lr_d;
`endif
    end
  end

  // Bus outputs decode from registers only, so there is no ready->req path.
  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = ip_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (state_q == S_MEM) && (opcode == OP_ST);
  assign dmem_addr  = addr_s;
  assign dmem_wdata = acc_q;

  assign acc_out = acc_q;
  assign ip_out  = ip_q;
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_acc_core.sv
// tb_acc_core
// Randomised, scoreboard-checked bench for acc_core (16-bit word, 12-bit
// address). An ISA-level interpreter predicts the bus transactions of each
// program: every fetch address and every data access. A monitor pops those
// predictions and compares them as the DUT completes handshakes. A memory
// responder inserts random wait states and stray ready pulses.
module tb_acc_core;

  localparam int W = 16;
  localparam int A = 12;

`ifdef ACC_CORE_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [A-1:0]  imem_addr;
  logic [W-1:0]  imem_rdata = '0;
  logic          imem_ready = 1'b0;
  logic          dmem_req;
  logic          dmem_we;
  logic [A-1:0]  dmem_addr;
  logic [W-1:0]  dmem_wdata;
  logic [W-1:0]  dmem_rdata = '0;
  logic          dmem_ready = 1'b0;
  logic [W-1:0]  acc_out;
  logic [A-1:0]  ip_out;
  logic          halted;
  logic          illegal;

  always #5 sysclk = ~sysclk;

  acc_core #(
    .WORD_SIZE    (W),
    .ADDR_SIZE    (A),
    .RESET_VECTOR (12'h000)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ready (dmem_ready),
    .acc_out    (acc_out),
    .ip_out     (ip_out),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Memories seen by the DUT, plus the model's private data image
  logic [W-1:0] rom     [4096];
  logic [W-1:0] dmem    [4096];
  logic [W-1:0] ref_mem [4096];

  typedef struct {
    bit           is_data;
    bit           we;
    logic [A-1:0] addr;
    logic [W-1:0] wdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t mon_t;

  int checks = 0;
  int errors = 0;

  int max_wait = 0;
  bit d_block  = 1'b0;
  bit mon_en   = 1'b0;
  int i_wait   = 0;
  int d_wait   = 0;

  logic [W-1:0] exp_acc;
  logic [A-1:0] exp_ip;
  logic         exp_ill;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic int pick();
    return int'($urandom_range(0, max_wait));
  endfunction

  // Memory responder: updates ready/data on the falling edge, so the DUT
  // samples them at the next rising edge.
  always @(negedge sysclk) begin
    if (imem_req) begin
      if (i_wait == 0) begin
        imem_ready = 1'b1;
        imem_rdata = rom[imem_addr];
        i_wait     = pick();
      end else begin
        imem_ready = 1'b0;
        imem_rdata = W'($urandom);
        i_wait--;
      end
    end else begin
      imem_ready = 1'($urandom_range(0, 1));  // stray ready, must be ignored
      imem_rdata = W'($urandom);
    end

    if (dmem_req && !d_block) begin
      if (d_wait == 0) begin
        dmem_ready = 1'b1;
        dmem_rdata = dmem[dmem_addr];
        if (dmem_we) dmem[dmem_addr] = dmem_wdata;
        d_wait     = pick();
      end else begin
        dmem_ready = 1'b0;
        dmem_rdata = W'($urandom);
        d_wait--;
      end
    end else begin
      dmem_ready = d_block ? 1'b0 : 1'($urandom_range(0, 1));
      dmem_rdata = W'($urandom);
    end
  end

  // Monitor: samples 2 time units before the rising edge, once ready/req
  // are settled for the coming handshake.
  bit           pi_wait = 1'b0;
  bit           pd_wait = 1'b0;
  logic [A-1:0] pi_addr;
  logic [A-1:0] pd_addr;
  logic         pd_we;
  logic [W-1:0] pd_wdata;

  always @(negedge sysclk) begin
    #3;
    if (!rst && mon_en) begin
      if (pi_wait) begin
        chk("imem_hold", 32'({imem_req, imem_addr}), 32'({1'b1, pi_addr}));
      end
      if (pd_wait) begin
        chk("dmem_hold", 32'({dmem_req, dmem_we, dmem_addr}), 32'({1'b1, pd_we, pd_addr}));
        chk("dmem_hold_wdata", 32'(dmem_wdata), 32'(pd_wdata));
      end
      if (imem_req && imem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_extra: fetch addr=%h but required no transaction", imem_addr);
        end else begin
          mon_t = exp_q.pop_front();
          chk("fetch", 32'({1'b0, imem_addr}), 32'({mon_t.is_data, mon_t.addr}));
          $display("txn fetch addr=%h ir=%h", imem_addr, imem_rdata);
        end
      end
      if (dmem_req && dmem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_extra: data addr=%h but required no transaction", dmem_addr);
        end else begin
          mon_t = exp_q.pop_front();
          chk("data", 32'({1'b1, dmem_we, dmem_addr}), 32'({mon_t.is_data, mon_t.we, mon_t.addr}));
          if (mon_t.we) chk("data_wdata", 32'(dmem_wdata), 32'(mon_t.wdata));
          $display("txn data we=%0b addr=%h wdata=%h rdata=%h", dmem_we, dmem_addr, dmem_wdata, dmem_rdata);
        end
      end
    end
    pi_wait  = !rst && imem_req && !imem_ready;
    pi_addr  = imem_addr;
    pd_wait  = !rst && dmem_req && !dmem_ready;
    pd_addr  = dmem_addr;
    pd_we    = dmem_we;
    pd_wdata = dmem_wdata;
  end

  // ISA-level reference: interprets the program and queues the expected bus
  // transactions. done=0 means the program did not finish within the limit.
  task automatic push_fetch(input logic [A-1:0] a);
    exp_q.push_back('{is_data: 1'b0, we: 1'b0, addr: a, wdata: '0});
  endtask

  task automatic push_data(input bit we, input logic [A-1:0] a, input logic [W-1:0] d);
    exp_q.push_back('{is_data: 1'b1, we: we, addr: a, wdata: d});
  endtask

  task automatic run_ref(input int limit, output bit done);
    logic [A-1:0] ip, lr, s;
    logic [W-1:0] acc, ir;
    int steps;
    ip = 12'h000; lr = 12'h000; acc = 16'h0000;
    done = 1'b0; exp_ill = 1'b0; steps = 0;
    exp_q.delete();
    for (int k = 0; k < 4096; k++) ref_mem[k] = dmem[k];
    while (!done && steps < limit) begin
      steps++;
      push_fetch(ip);
      ir = rom[ip];
      ip = ip + 12'd1;
      s  = ir[A-1:0];
      case (ir[15:12])
        4'h0: begin push_data(1'b0, s, '0); acc = ref_mem[s]; end
        4'h1: begin push_data(1'b1, s, acc); ref_mem[s] = acc; end
        4'h2: begin push_data(1'b0, s, '0); acc = acc + ref_mem[s]; end
        4'h3: begin push_data(1'b0, s, '0); acc = acc - ref_mem[s]; end
        4'h4: ip = s;
        4'h5: if (acc < 16'h8000) ip = s;
        4'h6: if (acc != 16'h0000) ip = s;
        4'h7: done = 1'b1;
        4'h8: begin push_data(1'b0, s, '0); acc = acc & ref_mem[s]; end
        4'h9: begin push_data(1'b0, s, '0); acc = acc | ref_mem[s]; end
        4'hA: begin push_data(1'b0, s, '0); acc = acc ^ ref_mem[s]; end
        4'hB: acc = {4'h0, ir[11:0]};
        4'hC: acc = acc * 16'd2;
        4'hD: acc = acc / 16'd2;
        4'hE: if (CALL_EN) begin lr = ip; ip = s; end else begin done = 1'b1; exp_ill = 1'b1; end
        default: if (CALL_EN) ip = lr; else begin done = 1'b1; exp_ill = 1'b1; end
      endcase
    end
    exp_acc = acc;
    exp_ip  = ip;
  endtask

  task automatic step();
    @(negedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic clear_mems();
    for (int k = 0; k < 4096; k++) begin
      rom[k]  = 16'h7000;
      dmem[k] = 16'h0000;
    end
  endtask

  // Runs the program currently in rom/dmem (reference already evaluated)
  // and checks the end state. cycles = rising edges until halted is seen.
  task automatic run_prog(input string name, input int mw, output int cycles);
    bit seen;
    int cyc;
    max_wait = mw;
    do_reset();
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 4000) begin
      @(negedge sysclk);
      #2;
      cyc++;
      if (halted) seen = 1'b1;
    end
    chk({name, "_halt_reached"}, 32'(seen), 32'(1));
    step();
    chk({name, "_no_req_halted"}, 32'({imem_req, dmem_req}), 32'(0));
    chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'(0));
    chk({name, "_acc"}, 32'(acc_out), 32'(exp_acc));
    chk({name, "_ip"}, 32'(ip_out), 32'(exp_ip));
    chk({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
    exp_q.delete();
    cycles = cyc;
  endtask

  task automatic load_add_prog();
    clear_mems();
    rom[0] = 16'hB005;   // LDI 5
    rom[1] = 16'h2010;   // ADD [0x10]
    rom[2] = 16'h1011;   // ST  [0x11]
    rom[3] = 16'h7000;   // HALT
    dmem[12'h010] = 16'h0003;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int cyc;
    int n;
    logic [3:0] op;
    logic [A-1:0] s;

    clear_mems();

    // Reset state while rst is held
    repeat (3) step();
    chk("rst_imem_req", 32'(imem_req), 32'(1));
    chk("rst_dmem_req_we", 32'({dmem_req, dmem_we}), 32'(0));
    chk("rst_acc", 32'(acc_out), 32'(0));
    chk("rst_ip", 32'(ip_out), 32'(0));
    chk("rst_halted_illegal", 32'({halted, illegal}), 32'(0));

    // Zero wait states: 2+3+3+2 = 10 edges, halted visible in cycle 11
    load_add_prog();
    run_ref(200, ok);
    run_prog("basic0", 0, cyc);
    chk("basic0_cycles", 32'(cyc), 32'(10));
    chk("basic0_mem11", 32'(dmem[12'h011]), 32'(16'h0008));
    chk("basic0_acc8", 32'(acc_out), 32'(16'h0008));

    // Same program with 0..3 wait states on both ports
    load_add_prog();
    run_ref(200, ok);
    run_prog("basic_wait", 3, cyc);
    chk("basic_wait_mem11", 32'(dmem[12'h011]), 32'(16'h0008));

    // Wrap to zero, branch flags, SHL dropping the MSB
    clear_mems();
    rom[0]  = 16'h0012;  // LD  [0x12] = FFFF
    rom[1]  = 16'h2013;  // ADD [0x13] = 1 -> 0
    rom[2]  = 16'h600A;  // JNZ 0x00A (not taken)
    rom[3]  = 16'h5008;  // JGE 0x008 (taken)
    rom[8]  = 16'h0014;  // LD  [0x14] = 8001
    rom[9]  = 16'hC000;  // SHL -> 0002
    rom[10] = 16'h1015;  // ST  [0x15]
    dmem[12'h012] = 16'hFFFF;
    dmem[12'h013] = 16'h0001;
    dmem[12'h014] = 16'h8001;
    run_ref(200, ok);
    run_prog("flags", 2, cyc);
    chk("flags_shl_mem15", 32'(dmem[12'h015]), 32'(16'h0002));

    // ip wrap: JMP 0xFFF, the LDI there runs, next fetch is 0x000
    clear_mems();
    rom[0]      = 16'h6002;  // JNZ 0x002
    rom[1]      = 16'h4FFF;  // JMP 0xFFF
    rom[12'hFFF] = 16'hB007; // LDI 7
    run_ref(200, ok);
    run_prog("wrap", 1, cyc);
    chk("wrap_acc", 32'(acc_out), 32'(16'h0007));

    // CALL / RET (illegal stop when the option is absent)
    clear_mems();
    rom[0]      = 16'hB001;
    rom[1]      = 16'hC000;
    rom[2]      = 16'hC000;
    rom[3]      = 16'hD000;
    rom[4]      = 16'hB00F;
    rom[5]      = 16'hE020;  // CALL 0x020
    rom[12'h020] = 16'hF000; // RET
    run_ref(200, ok);
    run_prog("call", 1, cyc);
    chk("call_illegal_flag", 32'(illegal), CALL_EN ? 32'(0) : 32'(1));

    // Reset during a stalled MEM access
    clear_mems();
    rom[0] = 16'hB123;  // LDI 0x123
    rom[1] = 16'h0010;  // LD [0x10], never acknowledged
    max_wait = 0;
    d_block  = 1'b1;
    rst      = 1'b1;
    repeat (3) step();
    mon_en   = 1'b0;
    rst      = 1'b0;
    cyc = 0;
    while (!dmem_req && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    step();
    chk("midmem_dreq", 32'(dmem_req), 32'(1));
    chk("midmem_acc", 32'(acc_out), 32'(16'h0123));
    rst = 1'b1;
    step();
    chk("midmem_rst_imem", 32'({imem_req, imem_addr}), 32'({1'b1, 12'h000}));
    chk("midmem_rst_dreq", 32'(dmem_req), 32'(0));
    chk("midmem_rst_acc", 32'(acc_out), 32'(0));
    rst     = 1'b0;
    d_block = 1'b0;

    // Random programs; regenerate any the reference does not finish
    for (int p = 0; p < 20; p++) begin
      ok = 1'b0;
      while (!ok) begin
        clear_mems();
        n = int'($urandom_range(6, 24));
        for (int k = 0; k < 32; k++) dmem[k] = W'($urandom);
        for (int i = 0; i < n; i++) begin
          op = 4'($urandom_range(0, 15));
          if (op == 4'h4 || op == 4'h5 || op == 4'h6 || op == 4'hE)
            s = A'($urandom_range(0, n));
          else if (op == 4'hB)
            s = A'($urandom);
          else
            s = A'($urandom_range(0, 31));
          rom[i] = {op, s};
        end
        run_ref(200, ok);
      end
      run_prog($sformatf("rand%0d", p), 3, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_core.md
# acc_core

Parametrised accumulator processor core: successor to the fixed 16-bit/12-bit single-accumulator control unit. Generalises word and address width, moves memory outside the core behind request/ready handshakes on separate instruction and data ports (wait states allowed), extends the ISA with logic, shift and immediate ops, and replaces simulation-only termination with a `halted` status output. Sits between the instruction ROM / data RAM and the system top.

## Interface
Parameters:
- `WORD_SIZE`, 16: data/instruction width; must be ≥ `ADDR_SIZE`+4.
- `ADDR_SIZE`, 12: instruction and data address width.
- `RESET_VECTOR`, 0: `ip` value after reset.

Ports:
- `sysclk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_req`  out  1  instruction fetch request.
- `imem_addr`  out  ADDR_SIZE  fetch address, equals `ip`.
- `imem_rdata`  in  WORD_SIZE  instruction word, valid when `imem_ready`.
- `imem_ready`  in  1  fetch complete this cycle.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  write qualifier for `dmem_req`.
- `dmem_addr`  out  ADDR_SIZE  `ir[ADDR_SIZE-1:0]`.
- `dmem_wdata`  out  WORD_SIZE  equals `acc`.
- `dmem_rdata`  in  WORD_SIZE  read data, valid when `dmem_ready`.
- `dmem_ready`  in  1  data access complete this cycle.
- `acc_out`  out  WORD_SIZE  accumulator.
- `ip_out`  out  ADDR_SIZE  instruction pointer.
- `halted`  out  1  core stopped.
- `illegal`  out  1  stopped on unsupported opcode.

## Operation
- Opcode `ir[WORD_SIZE-1:WORD_SIZE-4]`; address S = `ir[ADDR_SIZE-1:0]`; immediate = `ir[WORD_SIZE-5:0]` zero-extended.
- ISA: 0 LD acc:=[S]; 1 ST [S]:=acc; 2 ADD; 3 SUB; 4 JMP ip:=S; 5 JGE (acc MSB 0); 6 JNZ (acc≠0); 7 HALT; 8 AND; 9 OR; A XOR (all with [S]); B LDI acc:=imm; C SHL acc:=acc<<1; D SHR logical; E CALL; F RET (see Configuration).
- States: FETCH, DECODE, MEM, HALT.
- FETCH: `imem_req`=1. On `imem_ready`: `ir`:=`imem_rdata`, `ip`:=`ip`+1 mod 2^ADDR_SIZE → DECODE. Otherwise hold.
- DECODE: opcodes 0–3, 8–A → MEM. Jumps, LDI, shifts, CALL/RET execute here → FETCH. HALT → HALT. Illegal → HALT, `illegal`:=1.
- MEM: `dmem_req`=1, `dmem_we`=1 only for ST. On `dmem_ready`: update acc (loads/ALU) → FETCH. Otherwise hold with address/data stable.
- HALT: no requests; only `rst` exits.
- Arithmetic mod 2^WORD_SIZE; no carry/overflow flags. Branch taken: ip:=S overwrites the incremented value.

## Timing
- Reset values: state FETCH, `acc` 0, `ir` 0, `ip` RESET_VECTOR, `lr` 0, `halted` 0, `illegal` 0, `imem_req` 1 (first cycle after reset), `dmem_req`/`dmem_we` 0.
- Request outputs decode from state register only (Moore); no combinational path ready→req.
- Req stays high with stable address until the ready cycle; ready sampled only while matching req is high, otherwise ignored.
- Zero wait states: non-memory instruction 2 cycles, memory instruction 3 cycles; each wait cycle adds 1.
- `rst` dominates every state including mid-MEM; an outstanding ST may or may not complete in memory, core forgets it.
- `ip` wraps from 2^ADDR_SIZE-1 to 0.

## Configuration
- `ACC_CORE_CALL_EN` defined: link register `lr` (ADDR_SIZE) present. CALL: lr:=ip (already incremented), ip:=S. RET: ip:=lr. Single level, no stack.
- Undefined: no `lr`; opcodes E/F are illegal → HALT with `illegal`=1.

## Structure
- Package `acc_core_pkg`: opcode constants, state enum, field-position localparams.
- Sub-module `acc_core_alu`: combinational acc/operand/opcode → result (ADD, SUB, AND, OR, XOR, SHL, SHR, LD/LDI pass).

## Test plan
- Ready tied high, program LDI 5; ADD [0x10]=3; ST [0x11]; HALT → [0x11]=8, `halted`=1 after 11 cycles, `illegal`=0.
- Random 0–3 wait cycles on both ports, same program → same result, req/address stable while waiting.
- acc=0xFFFF, ADD [S]=1 → acc=0; JNZ not taken; JGE taken; SHL of 0x8001 → 0x0002.
- JMP to 0xFFF, instruction there executes, next fetch address 0x000.
- `rst` asserted during MEM with `dmem_ready` low → next cycle FETCH at RESET_VECTOR, `dmem_req`=0, acc=0.
- CALL 0x20 at 0x005, RET at 0x020 → next fetch 0x006 with macro; without macro CALL → `halted`=1, `illegal`=1.
